// File: rtl/ebus_pi_dev.sv
// EBUS device-side interrupt/IO front end: sticky interrupt flags, PI level
// request, and CONO/CONI/PI-vector-read function cycles with demand/xfer handshake.
module ebus_pi_dev #(
    parameter logic [6:0]  DEV_NUM  = 7'o10,
    parameter int          N_SRC    = 8,
    parameter logic [17:0] VEC_BASE = 18'o140,
    parameter bit          AUTO_CLR = 1'b1
) (
    input  logic             clk_h,
    input  logic             mr_reset_l,
    input  logic [0:6]       ebus_cs_h,
    input  logic [0:2]       ebus_f_h,
    input  logic             ebus_demand_h,
    input  logic [0:35]      ebus_d_in_h,
    output logic [0:35]      ebus_d_out_h,
    output logic             ebus_d_oe_h,
    output logic             ebus_xfer_h,
    output logic [0:7]       ebus_pi_h,
    input  logic             pi_sel_in_h,
    output logic             pi_sel_out_h,
    input  logic [N_SRC-1:0] dev_req_h
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_XFER, S_REL} state_t;
    typedef enum logic [1:0] {OP_CONO, OP_CONI, OP_PI} op_t;

    localparam logic [8:0] MASK9    = (9'd1 << N_SRC) - 9'd1;
    localparam logic [7:0] SRC_MASK = MASK9[7:0];

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [7:0]  flags_q, flags_d;
    logic        enable_q, enable_d;
    logic [2:0]  pia_q, pia_d;
    logic [2:0]  srv_q, srv_d;
    logic [7:0]  cono_clr_q, cono_clr_d;
    logic        cono_en_q, cono_en_d;
    logic [2:0]  cono_pia_q, cono_pia_d;
    logic [0:35] d_out_q, d_out_d;
    logic        oe_q, oe_d;
    logic        xfer_q, xfer_d;
    logic [0:7]  pi_q, pi_d;

    logic [7:0]  req_s;
    logic [7:0]  clr_s;
    logic [2:0]  lo_s;
    logic [17:0] vec_s;
    logic [0:35] coni_s;
    logic        cs_hit_s;
    logic        pi_hit_s;
    logic        claim_s;
    logic        unused_s;

    function automatic logic [2:0] lowest_idx(input logic [7:0] f);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (f[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign unused_s = ^{ebus_d_in_h[0:2], ebus_d_in_h[6:23]};

    // Decode helpers: selection, served source, CONI word.
    always_comb begin
        req_s = 8'd0;
        req_s[N_SRC-1:0] = dev_req_h;
        cs_hit_s = (ebus_cs_h == DEV_NUM);
        pi_hit_s = ebus_demand_h && (ebus_f_h == 3'd4) && enable_q &&
                   (flags_q != 8'd0) && (pia_q != 3'd0) &&
                   (ebus_d_in_h[3:5] == pia_q) && pi_sel_in_h;
        lo_s  = lowest_idx(flags_q);
        vec_s = VEC_BASE + {14'd0, lo_s, 1'b0};
        coni_s = 36'd0;
        for (int i = 0; i < 8; i++) begin
            coni_s[24+i] = flags_q[i];
        end
        coni_s[32]    = enable_q;
        coni_s[33:35] = pia_q;
    end

    // Claim covers the selecting cycle and every busy state of a PI read.
    always_comb begin
        if (state_q == S_IDLE) begin
            claim_s = pi_hit_s;
        end else begin
            claim_s = (op_q == OP_PI);
        end
    end

    assign pi_sel_out_h = pi_sel_in_h & ~claim_s;

    // Function-cycle FSM next state, side effects and registered outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        srv_d      = srv_q;
        cono_clr_d = cono_clr_q;
        cono_en_d  = cono_en_q;
        cono_pia_d = cono_pia_q;
        d_out_d    = d_out_q;
        oe_d       = oe_q;
        xfer_d     = xfer_q;
        enable_d   = enable_q;
        pia_d      = pia_q;
        clr_s      = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (ebus_demand_h && (ebus_f_h == 3'd0) && cs_hit_s) begin
                    state_d = S_DRIVE;
                    op_d    = OP_CONO;
                    for (int i = 0; i < 8; i++) begin
                        cono_clr_d[i] = ebus_d_in_h[24+i];
                    end
                    cono_en_d  = ebus_d_in_h[32];
                    cono_pia_d = ebus_d_in_h[33:35];
                    d_out_d    = 36'd0;
                    oe_d       = 1'b1;
                end else if (ebus_demand_h && (ebus_f_h == 3'd1) && cs_hit_s) begin
                    state_d = S_DRIVE;
                    op_d    = OP_CONI;
                    d_out_d = coni_s;
                    oe_d    = 1'b1;
                end else if (pi_hit_s) begin
                    state_d = S_DRIVE;
                    op_d    = OP_PI;
                    srv_d   = lo_s;
                    d_out_d = {3'b010, pia_q, 12'd0, vec_s};
                    oe_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (ebus_demand_h) begin
                    state_d = S_XFER;
                    xfer_d  = 1'b1;
                    if (op_q == OP_CONO) begin
                        clr_s    = cono_clr_q & SRC_MASK;
                        enable_d = cono_en_q;
                        pia_d    = cono_pia_q;
                    end else if ((op_q == OP_PI) && AUTO_CLR) begin
                        clr_s[srv_q] = 1'b1;
                    end else begin
                        clr_s = 8'd0;
                    end
                end else begin
                    // Early demand drop aborts with no register side effects.
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    d_out_d = 36'd0;
                end
            end
            S_XFER: begin
                if (!ebus_demand_h) begin
                    state_d = S_REL;
                    xfer_d  = 1'b0;
                    oe_d    = 1'b0;
                    d_out_d = 36'd0;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                xfer_d  = 1'b0;
                oe_d    = 1'b0;
                d_out_d = 36'd0;
            end
        endcase
        flags_d = ((flags_q & ~clr_s) | req_s) & SRC_MASK;
        pi_d = 8'd0;
        if (enable_d && (flags_d != 8'd0) && (pia_d != 3'd0)) begin
            pi_d[pia_d] = 1'b1;
        end else begin
            pi_d = 8'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q    <= S_IDLE;
            op_q       <= OP_CONO;
            flags_q    <= 8'd0;
            enable_q   <= 1'b0;
            pia_q      <= 3'd0;
            srv_q      <= 3'd0;
            cono_clr_q <= 8'd0;
            cono_en_q  <= 1'b0;
            cono_pia_q <= 3'd0;
            d_out_q    <= 36'd0;
            oe_q       <= 1'b0;
            xfer_q     <= 1'b0;
            pi_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            flags_q    <= flags_d;
            enable_q   <= enable_d;
            pia_q      <= pia_d;
            srv_q      <= srv_d;
            cono_clr_q <= cono_clr_d;
            cono_en_q  <= cono_en_d;
            cono_pia_q <= cono_pia_d;
            d_out_q    <= d_out_d;
            oe_q       <= oe_d;
            xfer_q     <= xfer_d;
            pi_q       <= pi_d;
        end
    end

    assign ebus_d_out_h = d_out_q;
    assign ebus_d_oe_h  = oe_q;
    assign ebus_xfer_h  = xfer_q;
    assign ebus_pi_h    = pi_q;

endmodule

// File: tb/tb_ebus_pi_dev.sv
// Directed, table-driven bench for ebus_pi_dev plus hand-written corner sequences.
module tb_ebus_pi_dev;

    logic        clk_h = 1'b0;
    logic        mr_reset_l = 1'b0;
    logic [0:6]  ebus_cs_h = 7'd0;
    logic [0:2]  ebus_f_h = 3'd0;
    logic        ebus_demand_h = 1'b0;
    logic [0:35] ebus_d_in_h = 36'd0;
    logic [0:35] ebus_d_out_h;
    logic        ebus_d_oe_h;
    logic        ebus_xfer_h;
    logic [0:7]  ebus_pi_h;
    logic        pi_sel_in_h = 1'b1;
    logic        pi_sel_out_h;
    logic [7:0]  dev_req_h = 8'd0;

    int checks = 0;
    int errors = 0;

    ebus_pi_dev dut (
        .clk_h(clk_h), .mr_reset_l(mr_reset_l), .ebus_cs_h(ebus_cs_h),
        .ebus_f_h(ebus_f_h), .ebus_demand_h(ebus_demand_h),
        .ebus_d_in_h(ebus_d_in_h), .ebus_d_out_h(ebus_d_out_h),
        .ebus_d_oe_h(ebus_d_oe_h), .ebus_xfer_h(ebus_xfer_h),
        .ebus_pi_h(ebus_pi_h), .pi_sel_in_h(pi_sel_in_h),
        .pi_sel_out_h(pi_sel_out_h), .dev_req_h(dev_req_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic [7:0]  req;
        logic [0:7]  pre_pi;
        logic [2:0]  f;
        logic [6:0]  cs;
        logic [35:0] d;
        logic        sel;
        logic        oe;
        logic        xf;
        logic [35:0] dout;
        logic        selout;
        logic [0:7]  post_pi;
    } vec_t;

    localparam logic [0:7]  P0 = 8'b0000_0000;
    localparam logic [0:7]  P3 = 8'b0001_0000;
    localparam logic [35:0] L3 = 36'o030000000000;
    localparam logic [35:0] L4 = 36'o040000000000;

    vec_t vecs[17];

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %o expected %o", name, got, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.req != 8'd0) begin
            @(negedge clk_h);
            dev_req_h = v.req;
            @(negedge clk_h);
            dev_req_h = 8'd0;
            check({tag, " pre_pi"}, 36'(ebus_pi_h), 36'(v.pre_pi));
        end
        @(negedge clk_h);
        ebus_f_h = v.f; ebus_cs_h = v.cs; ebus_d_in_h = v.d;
        pi_sel_in_h = v.sel; ebus_demand_h = 1'b1;
        @(posedge clk_h); #1;
        check({tag, " drive_oe"}, 36'(ebus_d_oe_h), 36'(v.oe));
        check({tag, " drive_data"}, 36'(ebus_d_out_h), v.dout);
        check({tag, " sel_out"}, 36'(pi_sel_out_h), 36'(v.selout));
        @(posedge clk_h); #1;
        check({tag, " xfer"}, 36'(ebus_xfer_h), 36'(v.xf));
        @(negedge clk_h);
        ebus_demand_h = 1'b0;
        @(posedge clk_h); #1;
        check({tag, " rel_oe_xfer"}, {34'd0, ebus_d_oe_h, ebus_xfer_h}, 36'd0);
        @(posedge clk_h); #1;
        check({tag, " post_pi"}, 36'(ebus_pi_h), 36'(v.post_pi));
        pi_sel_in_h = 1'b1;
    endtask

    initial begin
        vec_t cv;
        //           req    pre  f     cs     d               sel  oe    xf    dout                  so    post
        vecs[0]  = '{8'h00, P0, 3'd0, 7'o10, 36'o13,          1'b1, 1'b1, 1'b1, 36'd0,             1'b1, P0};
        vecs[1]  = '{8'h00, P0, 3'd1, 7'o10, 36'd0,           1'b1, 1'b1, 1'b1, 36'o13,            1'b1, P0};
        vecs[2]  = '{8'h20, P3, 3'd4, 7'o00, L3,              1'b1, 1'b1, 1'b1, 36'o230000000152,  1'b0, P0};
        vecs[3]  = '{8'h44, P3, 3'd4, 7'o00, L3,              1'b1, 1'b1, 1'b1, 36'o230000000144,  1'b0, P3};
        vecs[4]  = '{8'h00, P0, 3'd4, 7'o00, L3,              1'b1, 1'b1, 1'b1, 36'o230000000154,  1'b0, P0};
        vecs[5]  = '{8'h01, P3, 3'd4, 7'o00, L3,              1'b0, 1'b0, 1'b0, 36'd0,             1'b0, P3};
        vecs[6]  = '{8'h00, P0, 3'd4, 7'o00, L4,              1'b1, 1'b0, 1'b0, 36'd0,             1'b1, P3};
        vecs[7]  = '{8'h00, P0, 3'd2, 7'o10, 36'd0,           1'b1, 1'b0, 1'b0, 36'd0,             1'b1, P3};
        vecs[8]  = '{8'h00, P0, 3'd0, 7'o11, 36'd0,           1'b1, 1'b0, 1'b0, 36'd0,             1'b1, P3};
        vecs[9]  = '{8'h00, P0, 3'd1, 7'o10, 36'd0,           1'b1, 1'b1, 1'b1, 36'o4013,          1'b1, P3};
        vecs[10] = '{8'h00, P0, 3'd0, 7'o10, 36'o4013,        1'b1, 1'b1, 1'b1, 36'd0,             1'b1, P0};
        vecs[11] = '{8'h00, P0, 3'd1, 7'o10, 36'd0,           1'b1, 1'b1, 1'b1, 36'o13,            1'b1, P0};
        vecs[12] = '{8'h80, P3, 3'd0, 7'o10, 36'o3,           1'b1, 1'b1, 1'b1, 36'd0,             1'b1, P0};
        vecs[13] = '{8'h00, P0, 3'd1, 7'o10, 36'd0,           1'b1, 1'b1, 1'b1, 36'o23,            1'b1, P0};
        vecs[14] = '{8'h00, P0, 3'd4, 7'o00, L3,              1'b1, 1'b0, 1'b0, 36'd0,             1'b1, P0};
        vecs[15] = '{8'h00, P0, 3'd0, 7'o10, 36'o33,          1'b1, 1'b1, 1'b1, 36'd0,             1'b1, P0};
        vecs[16] = '{8'h00, P0, 3'd1, 7'o10, 36'd0,           1'b1, 1'b1, 1'b1, 36'o13,            1'b1, P0};

        #12;
        check("reset outputs", {ebus_d_out_h}, 36'd0);
        check("reset ctl", {26'd0, ebus_pi_h, ebus_d_oe_h, ebus_xfer_h}, 36'd0);
        check("reset sel_out", 36'(pi_sel_out_h), 36'd1);
        @(negedge clk_h);
        mr_reset_l = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec(i, vecs[i]);
        end

        // Set and CONO clear of flag 1 on the same edge: set wins.
        @(negedge clk_h); dev_req_h = 8'h02;
        @(negedge clk_h); dev_req_h = 8'h00;
        @(negedge clk_h);
        ebus_f_h = 3'd0; ebus_cs_h = 7'o10; ebus_d_in_h = 36'o2013; ebus_demand_h = 1'b1;
        @(posedge clk_h);
        @(negedge clk_h); dev_req_h = 8'h02;
        @(posedge clk_h); #1;
        check("same_edge xfer", 36'(ebus_xfer_h), 36'd1);
        @(negedge clk_h); dev_req_h = 8'h00; ebus_demand_h = 1'b0;
        @(posedge clk_h); @(posedge clk_h); #1;
        check("same_edge pi", 36'(ebus_pi_h), 36'(P3));
        cv = '{8'h00, P0, 3'd1, 7'o10, 36'd0, 1'b1, 1'b1, 1'b1, 36'o2013, 1'b1, P3};
        run_vec(100, cv);

        // CONO aborted by demand dropping in DRIVE.
        @(negedge clk_h);
        ebus_f_h = 3'd0; ebus_cs_h = 7'o10; ebus_d_in_h = 36'd0; ebus_demand_h = 1'b1;
        @(posedge clk_h); #1;
        check("abort drive_oe", 36'(ebus_d_oe_h), 36'd1);
        @(negedge clk_h); ebus_demand_h = 1'b0;
        @(posedge clk_h); #1;
        check("abort idle", {34'd0, ebus_d_oe_h, ebus_xfer_h}, 36'd0);
        @(posedge clk_h); #1;
        check("abort xfer", 36'(ebus_xfer_h), 36'd0);
        run_vec(101, cv);

        // Asynchronous reset while xfer is high.
        @(negedge clk_h);
        ebus_f_h = 3'd1; ebus_cs_h = 7'o10; ebus_d_in_h = 36'd0; ebus_demand_h = 1'b1;
        @(posedge clk_h); @(posedge clk_h); #1;
        check("prereset xfer", 36'(ebus_xfer_h), 36'd1);
        #2; mr_reset_l = 1'b0; #1;
        check("async rst ctl", {26'd0, ebus_pi_h, ebus_d_oe_h, ebus_xfer_h}, 36'd0);
        check("async rst data", ebus_d_out_h, 36'd0);
        ebus_demand_h = 1'b0;
        @(negedge clk_h); mr_reset_l = 1'b1;
        cv = '{8'h00, P0, 3'd1, 7'o10, 36'd0, 1'b1, 1'b1, 1'b1, 36'd0, 1'b1, P0};
        run_vec(102, cv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
